// File: rtl/decoder3to8_beh_alw_if.sv
// Select/enable inputs and registered one-hot outputs of the 3-to-8 decoder.
// master: control side driving the select; slave: the decoder itself.
interface decoder3to8_beh_alw_if;
  logic en;
  logic A;
  logic B;
  logic C;
  logic Y0;
  logic Y1;
  logic Y2;
  logic Y3;
  logic Y4;
  logic Y5;
  logic Y6;
  logic Y7;
  logic valid;

  modport master (
    output en, A, B, C,
    input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, valid
  );

  modport slave (
    input  en, A, B, C,
    output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, valid
  );
endinterface

// File: rtl/decoder3to8_beh_alw.sv
// Registered 3-to-8 one-hot decoder with enable and asynchronous active-high reset.
// Optional DEC38_HOLD_EN: en=0 holds the previous Y outputs instead of clearing them.
module decoder3to8_beh_alw (
  input  logic                        clk,
  input  logic                        rst,
  decoder3to8_beh_alw_if.slave        bus
);

  logic [2:0] sel;
  logic [7:0] y_d, y_q;
  logic       valid_d, valid_q;

  assign sel = {bus.A, bus.B, bus.C};

  always_comb begin
    y_d     = 8'h00;
    valid_d = bus.en;
    if (bus.en) begin
      unique case (sel)
        3'd0:    y_d = 8'b0000_0001;
        3'd1:    y_d = 8'b0000_0010;
        3'd2:    y_d = 8'b0000_0100;
        3'd3:    y_d = 8'b0000_1000;
        3'd4:    y_d = 8'b0001_0000;
        3'd5:    y_d = 8'b0010_0000;
        3'd6:    y_d = 8'b0100_0000;
        3'd7:    y_d = 8'b1000_0000;
        // Unknown select bits must never light more than one output.
        default: y_d = 8'h00;
      endcase
    end else begin
`ifdef DEC38_HOLD_EN
      y_d = y_q;
`else
      y_d = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Y0    = y_q[0];
  assign bus.Y1    = y_q[1];
  assign bus.Y2    = y_q[2];
  assign bus.Y3    = y_q[3];
  assign bus.Y4    = y_q[4];
  assign bus.Y5    = y_q[5];
  assign bus.Y6    = y_q[6];
  assign bus.Y7    = y_q[7];
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_decoder3to8_beh_alw.sv
// Directed and random checks of the registered 3-to-8 decoder.
// Expected values follow DEC38_HOLD_EN when the bench is built with it.
module tb_decoder3to8_beh_alw;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  decoder3to8_beh_alw_if bus ();

  decoder3to8_beh_alw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] y;
  assign y = {bus.Y7, bus.Y6, bus.Y5, bus.Y4, bus.Y3, bus.Y2, bus.Y1, bus.Y0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic en, input logic [2:0] sel);
    bus.en = en;
    {bus.A, bus.B, bus.C} = sel;
  endtask

  task automatic test_reset;
    drive(1'b1, 3'd5);
    #2 rst = 1'b1;
    #1;
    total++;
    if (y !== 8'h00 || bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_immediate: y=%b valid=%b want y=00000000 valid=0", y, bus.valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      total++;
      if (y !== 8'h00 || bus.valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_held[%0d]: y=%b valid=%b want y=00000000 valid=0", i, y, bus.valid);
      end
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    total++;
    if (y !== 8'b0010_0000 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: y=%b valid=%b want y=00100000 valid=1", y, bus.valid);
    end
  endtask

  task automatic test_disabled;
    logic [7:0] exp_y;
`ifdef DEC38_HOLD_EN
    exp_y = 8'b0010_0000;
`else
    exp_y = 8'h00;
`endif
    @(negedge clk) drive(1'b0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      total++;
      if (y !== exp_y || bus.valid !== 1'b0) begin
        bad++;
        $display("FAIL disabled[%0d]: y=%b valid=%b want y=%b valid=0", i, y, bus.valid, exp_y);
      end
    end
  endtask

  task automatic test_sweep;
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int s = 0; s < 8; s++) begin
      @(negedge clk) drive(1'b1, 3'(s));
      @(posedge clk) #1;
      total++;
      if (y !== exp_tab[s] || bus.valid !== 1'b1) begin
        bad++;
        $display("FAIL sweep_sel%0d: y=%b valid=%b want y=%b valid=1", s, y, bus.valid,
                 exp_tab[s]);
      end
    end
  endtask

  task automatic test_latency;
    @(negedge clk) drive(1'b1, 3'd2);
    @(posedge clk) #1;
    total++;
    if (y !== 8'b0000_0100) begin
      bad++;
      $display("FAIL latency_sel2: y=%b want 00000100", y);
    end
    @(negedge clk) drive(1'b1, 3'd6);
    #2;
    total++;
    if (y !== 8'b0000_0100 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_between_edges: y=%b valid=%b want y=00000100 valid=1", y, bus.valid);
    end
    @(posedge clk) #1;
    total++;
    if (y !== 8'b0100_0000) begin
      bad++;
      $display("FAIL latency_sel6: y=%b want 01000000", y);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk) drive(1'b1, 3'd7);
    @(posedge clk) #1;
    total++;
    if (y !== 8'b1000_0000) begin
      bad++;
      $display("FAIL async_pre: y=%b want 10000000", y);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (y !== 8'h00 || bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: y=%b valid=%b want y=00000000 valid=0", y, bus.valid);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    total++;
    if (y !== 8'b1000_0000 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL async_restore: y=%b valid=%b want y=10000000 valid=1", y, bus.valid);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_y;
    logic       en;
    logic [2:0] sel;
    int         ones;
    exp_y = y;
    for (int i = 0; i < 1000; i++) begin
      en  = 1'($urandom_range(0, 1));
      sel = 3'($urandom_range(0, 7));
      @(negedge clk) drive(en, sel);
      if (en) exp_y = 8'h01 << sel;
`ifndef DEC38_HOLD_EN
      else exp_y = 8'h00;
`endif
      @(posedge clk) #1;
      ones = $countones(y);
      total++;
      if (y !== exp_y || bus.valid !== en) begin
        bad++;
        $display("FAIL random[%0d]: y=%b valid=%b pop=%0d want y=%b valid=%b", i, y, bus.valid,
                 ones, exp_y, en);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 3'd0);
    test_reset();
    test_disabled();
    test_sweep();
    test_latency();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
